dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_W, 16, data word width.
REQ-002 SHALL have parameter ADDR_W, 16, word address width.
REQ-003 SHALL have parameter WB_DEPTH, 4, write-buffer entries (power of two, >=2).
REQ-004 SHALL have one clock; reset is asynchronous and active-high: ports clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-005 SHALL have req_valid  in  1  CPU load/store request; req_ready  out  1  request accepted when both high.
REQ-006 SHALL have req_we  in  1  1=store, 0=load; req_addr  in  ADDR_W; req_wdata  in  DATA_W  store data.
REQ-007 SHALL have rsp_valid  out  1  one-cycle load-data pulse; rsp_rdata  out  DATA_W  load data.
REQ-008 SHALL have mem_valid  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  backing-memory request.
REQ-009 SHALL have mem_ack  in  1  completes current mem request; mem_rdata  in  DATA_W  read data, valid with mem_ack.
REQ-010 SHALL have wb_empty  out  1  high when buffer empty and memory port idle.

Function
REQ-011 SHALL drive req_ready = !full && !load_pending, combinationally from registered state only.
REQ-012 SHALL enqueue an accepted store into a FIFO write buffer; stores never produce rsp_valid.
REQ-013 SHALL search an accepted load against all valid buffer entries; on match, forward data from the youngest matching entry with rsp_valid the next cycle (latency 1).
REQ-014 SHALL, on load miss, set load_pending, capturing the address; req_ready low until the response is issued.
REQ-015 SHALL run a memory-port FSM with states M_IDLE, M_WR, M_RD.
REQ-016 M_IDLE -> M_RD when load_pending (priority over drain); M_IDLE -> M_WR when buffer non-empty and no load pending.
REQ-017 M_WR/M_RD SHALL hold mem_valid high with mem_we/mem_addr/mem_wdata stable until the cycle mem_ack is high, then return to M_IDLE.
REQ-018 SHALL pop the buffer head in the cycle mem_ack completes an M_WR transaction.
REQ-019 SHALL, on mem_ack in M_RD, register mem_rdata to rsp_rdata, pulse rsp_valid the next cycle, and clear load_pending that same cycle.
REQ-020 SHALL issue mem_valid the cycle after entering M_WR/M_RD; minimum miss latency is accept->mem_valid 1 cycle, mem_ack->rsp_valid 1 cycle.
REQ-021 SHALL treat mem_ack while mem_valid low as ignored.
REQ-022 Simultaneous store enqueue and drain pop SHALL leave count unchanged; full blocks enqueue even when a pop occurs that cycle.
REQ-023 A load hit never touches the memory port; a miss bypasses older buffered stores to other addresses.
REQ-024 Pointers SHALL wrap modulo WB_DEPTH; count SHALL range 0..WB_DEPTH.
REQ-025 rsp_rdata SHALL hold its last value when rsp_valid is low.

Reset
REQ-026 rst SHALL asynchronously clear: FSM to M_IDLE, pointers/count to 0, entry valids, load_pending, rsp_valid, mem_valid, mem_we to 0; mem_addr, mem_wdata, rsp_rdata to 0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding memory request and discard buffered stores; after release req_ready=1, wb_empty=1.

Structure
REQ-028 A shared package dmem_pkg SHALL hold the memory-port state enum and the default width constants.
REQ-029 The write buffer with address match and youngest-hit select SHALL be sub-module dmem_wbuf; dmem_responder keeps the FSM and handshakes.

Verification
REQ-030 Store 0x0010<-0xBEEF, then load 0x0010 next cycle -> rsp_valid 1 cycle later with 0xBEEF; no mem read issued.
REQ-031 Stores 0x0020<-0x1111 then 0x0020<-0x2222, load 0x0020 -> 0x2222 forwarded; memory later sees writes in order 0x1111, 0x2222.
REQ-032 mem_ack held low: 4 stores fill buffer -> req_ready=0 on 5th; single ack -> one pop, req_ready=1 next cycle.
REQ-033 Load miss 0x0100, memory returns 0x5A5A after 3-cycle ack delay -> rsp_valid once with 0x5A5A, req_ready low throughout.
REQ-034 Buffered stores pending plus load miss -> M_RD issued before remaining drains once current write acks.
REQ-035 Assert rst during M_RD with 2 buffered stores -> mem_valid=0 immediately, wb_empty=1, no rsp_valid after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: memory-port states and
// default widths.
package dmem_pkg;
  localparam int DMEM_DATA_W   = 16;
  localparam int DMEM_ADDR_W   = 16;
  localparam int DMEM_WB_DEPTH = 4;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WR   = 2'd1,
    M_RD   = 2'd2
  } mport_state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// CPU request/response and backing-memory signals of the responder;
// slave is the responder's view, master the environment's.
interface dmem_responder_if import dmem_pkg::*; #(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_empty;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_valid, mem_we, mem_addr,
           mem_wdata, wb_empty
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_valid, mem_we, mem_addr,
           mem_wdata, wb_empty
  );
endinterface

// File: rtl/dmem_wbuf.sv
// FIFO store buffer with a fully associative address lookup that forwards
// the youngest matching entry.
module dmem_wbuf import dmem_pkg::*; #(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [PW-1:0]     idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld_q[wr_ptr]  <= 1'b1;
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (vld_q[idx] && (addr_q[idx] == look_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: buffers stores, forwards load hits from the buffer,
// and serialises misses and drains onto a single backing-memory port.
module dmem_responder import dmem_pkg::*; #(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  mport_state_t      state, state_nx;
  logic              load_pending;
  logic [ADDR_W-1:0] ld_addr;
  logic              mem_valid_q, mem_we_q, rsp_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rsp_rdata_q;

  logic              wb_full, wb_is_empty, wb_hit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, hit_data;
  logic              accept, acc_load, acc_store, ld_hit, ld_miss;
  logic              ack, wr_done, rd_done;

  assign bus.req_ready = !wb_full && !load_pending;
  assign accept        = bus.req_valid && bus.req_ready;
  assign acc_store     = accept && bus.req_we;
  assign acc_load      = accept && !bus.req_we;
  assign ld_hit        = acc_load && wb_hit;
  assign ld_miss       = acc_load && !wb_hit;
  assign ack           = mem_valid_q && bus.mem_ack;
  assign wr_done       = ack && (state == M_WR);
  assign rd_done       = ack && (state == M_RD);

  dmem_wbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (acc_store),
    .push_addr (bus.req_addr),
    .push_data (bus.req_wdata),
    .pop       (wr_done),
    .look_addr (bus.req_addr),
    .full      (wb_full),
    .empty     (wb_is_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .hit       (wb_hit),
    .hit_data  (hit_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= M_IDLE;
    else     state <= state_nx;
  end

  // A miss accepted while idle launches the read at once, without waiting
  // for load_pending to register.
  always_comb begin
    state_nx = state;
    unique case (state)
      M_IDLE: begin
        if (load_pending || ld_miss) state_nx = M_RD;
        else if (!wb_is_empty)       state_nx = M_WR;
      end
      M_WR:    if (ack) state_nx = M_IDLE;
      M_RD:    if (ack) state_nx = M_IDLE;
      default: state_nx = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_pending <= 1'b0;
      ld_addr      <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (ld_miss) begin
        load_pending <= 1'b1;
        ld_addr      <= bus.req_addr;
      end
      if (ld_hit) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= hit_data;
      end
      if (rd_done) begin
        rsp_valid_q  <= 1'b1;
        rsp_rdata_q  <= bus.mem_rdata;
        load_pending <= 1'b0;
      end
      if (state == M_IDLE && state_nx == M_RD) begin
        mem_valid_q <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= load_pending ? ld_addr : bus.req_addr;
      end else if (state == M_IDLE && state_nx == M_WR) begin
        mem_valid_q <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= head_addr;
        mem_wdata_q <= head_data;
      end else if (ack) begin
        mem_valid_q <= 1'b0;
        mem_we_q    <= 1'b0;
      end
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.wb_empty  = wb_is_empty && (state == M_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores against a
// behavioural backing memory with controllable acknowledge timing.
module tb_dmem_responder;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  txn_t        exp_txn[$];
  rsp_t        exp_rsp[$];
  logic [DW-1:0] mem_model [int];
  int unsigned n_rd = 0;

  int unsigned ack_delay = 0;
  bit          ack_hold = 1'b0;
  bit          ack_once = 1'b0;
  bit          stray_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected rdata for loads travels in 'data'; rsp_off=0 means latency unchecked.
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input int unsigned rsp_off);
    int unsigned guard;
    txn_t t;
    rsp_t r;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) chk("req_accept_timeout", {31'd0, bus.req_ready}, 32'd1);
    if (we) begin
      t = '{we: 1'b1, addr: addr, data: data};
      exp_txn.push_back(t);
    end else begin
      r = '{data: data, due: (rsp_off == 0) ? 0 : cyc + rsp_off};
      exp_rsp.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(bus.wb_empty && exp_rsp.size() == 0) && g < 300);
    chk("drain_done", {31'd0, bus.wb_empty}, 32'd1);
    chk("txn_left", exp_txn.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rdata %h, expected no response (cycle %0d)",
                   bus.rsp_rdata, cyc);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, r.data);
          if (r.due != 0) chk("rsp_cycle", cyc, r.due);
        end
      end
    end
  end

  // Backing memory: acks after ack_delay waiting cycles unless held.
  initial begin
    int unsigned   wait_cnt;
    bit            prev_pend;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    txn_t          t;
    wait_cnt = 0;
    prev_pend = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
        prev_pend = 1'b0;
      end else if (bus.mem_valid) begin
        if (prev_pend) begin
          chk("mem_hold_we", {31'd0, bus.mem_we}, {31'd0, p_we});
          chk("mem_hold_addr", bus.mem_addr, p_addr);
          if (p_we) chk("mem_hold_wdata", bus.mem_wdata, p_wdata);
        end
        if (wait_cnt >= ack_delay && (!ack_hold || ack_once)) begin
          ack_once = 1'b0;
          wait_cnt = 0;
          prev_pend = 1'b0;
          bus.mem_ack = 1'b1;
          if (exp_txn.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: got we=%b addr=%h, expected no transaction",
                     bus.mem_we, bus.mem_addr);
          end else begin
            t = exp_txn.pop_front();
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, t.we});
            chk("mem_addr", bus.mem_addr, t.addr);
            if (t.we) chk("mem_wdata", bus.mem_wdata, t.data);
          end
          if (bus.mem_we) mem_model[int'(bus.mem_addr)] = bus.mem_wdata;
          else begin
            n_rd++;
            bus.mem_rdata = mem_model.exists(int'(bus.mem_addr)) ?
                            mem_model[int'(bus.mem_addr)] : '0;
          end
        end else begin
          wait_cnt++;
          prev_pend = 1'b1;
          p_we = bus.mem_we;
          p_addr = bus.mem_addr;
          p_wdata = bus.mem_wdata;
        end
      end else begin
        prev_pend = 1'b0;
        if (stray_ack) begin
          stray_ack = 1'b0;
          bus.mem_ack = 1'b1;
          bus.mem_rdata = 16'hDEAD;
        end
      end
    end
  end

  initial begin
    int unsigned n0, g;
    txn_t t;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    mem_model[16'h0100] = 16'h5A5A;
    mem_model[16'h0200] = 16'h1234;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_wb_empty", {31'd0, bus.wb_empty}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk);
    #1;

    // Store then immediate load: forwarded with latency 1, no memory read.
    n0 = n_rd;
    issue(1'b1, 16'h0010, 16'hBEEF, 0);
    issue(1'b0, 16'h0010, 16'hBEEF, 1);
    wait_idle();
    chk("hit_no_read", n_rd, n0);

    // Two stores to one address: youngest forwarded, both written in order.
    ack_hold = 1'b1;
    n0 = n_rd;
    issue(1'b1, 16'h0020, 16'h1111, 0);
    issue(1'b1, 16'h0020, 16'h2222, 0);
    issue(1'b0, 16'h0020, 16'h2222, 1);
    ack_hold = 1'b0;
    wait_idle();
    chk("youngest_no_read", n_rd, n0);
    chk("mem_0020_final", mem_model[16'h0020], 32'h2222);

    // Fill buffer with acks held; fifth store blocked until one pop.
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 16'h0030 + 16'(i), 16'hC000 + 16'(i), 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0034;
    bus.req_wdata = 16'h5555;
    chk("full_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    ack_once = 1'b1;
    @(negedge clk);
    chk("full_ready_at_ack", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
    t = '{we: 1'b1, addr: 16'h0034, data: 16'h5555};
    exp_txn.push_back(t);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    ack_hold = 1'b0;
    wait_idle();

    // Load miss with delayed ack.
    ack_delay = 3;
    t = '{we: 1'b0, addr: 16'h0100, data: '0};
    exp_txn.push_back(t);
    issue(1'b0, 16'h0100, 16'h5A5A, 5);
    @(negedge clk);
    chk("miss_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("miss_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("miss_mem_addr", bus.mem_addr, 32'h0100);
    chk("miss_ready_0", {31'd0, bus.req_ready}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("miss_ready_low", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("miss_ready_back", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rdata_hold", bus.rsp_rdata, 32'h5A5A);
    @(posedge clk);
    #1;
    ack_delay = 0;
    wait_idle();

    // Stray ack while idle changes nothing.
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("stray_wb_empty", {31'd0, bus.wb_empty}, 32'd1);
    @(posedge clk);
    #1;

    // Miss overtakes remaining drains once the in-flight write completes.
    ack_hold = 1'b1;
    issue(1'b1, 16'h0040, 16'hA0A0, 0);
    issue(1'b1, 16'h0041, 16'hA1A1, 0);
    issue(1'b0, 16'h0200, 16'h1234, 0);
    t = '{we: 1'b0, addr: 16'h0200, data: '0};
    exp_txn.insert(1, t);
    ack_hold = 1'b0;
    wait_idle();

    // Reset during an outstanding read with stores still buffered.
    ack_hold = 1'b1;
    issue(1'b1, 16'h0050, 16'hB050, 0);
    issue(1'b1, 16'h0051, 16'hB051, 0);
    issue(1'b1, 16'h0052, 16'hB052, 0);
    issue(1'b0, 16'h0300, 16'h0000, 0);
    ack_once = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(bus.mem_valid && !bus.mem_we) && g < 50);
    chk("pre_rst_rd_addr", bus.mem_addr, 32'h0300);
    chk("pre_rst_wb_empty", {31'd0, bus.wb_empty}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mid_wb_empty", {31'd0, bus.wb_empty}, 32'd1);
    exp_txn.delete();
    exp_rsp.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post_rst_wb_empty", {31'd0, bus.wb_empty}, 32'd1);
    chk("post_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rsp_left", exp_rsp.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
